// File: rtl/led_pkg.sv
// Package: led_pkg
// Shared constants and helpers for the LED fader output stage.
//   NUMBER_OF_LEDS_DEFAULT  default channel count (Tang Nano 9K has 6 LEDs)
//   level_max()             full-scale brightness for a given PWM resolution
package led_pkg;

    localparam int unsigned NUMBER_OF_LEDS_DEFAULT = 6;

    // Full-scale brightness: 2**pwm_bits - 1
    function automatic int unsigned level_max(input int unsigned pwm_bits);
        return (32'd1 << pwm_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fader_if.sv
// Interface: led_fader_if
// Pattern-in / LED-out bundle between the pattern generator and the fader.
//   pattern_in  NUMBER_OF_LEDS  raw pattern, active-low (0 = LED requested on)
//   led         NUMBER_OF_LEDS  LED pins, active-low (0 = LED lit)
// Modports:
//   master  pattern source side (drives pattern_in, observes led)
//   slave   fader side (reads pattern_in, drives led)
interface led_fader_if import led_pkg::*; #(
    parameter int unsigned NUMBER_OF_LEDS = NUMBER_OF_LEDS_DEFAULT
);

    logic [NUMBER_OF_LEDS-1:0] pattern_in;
    logic [NUMBER_OF_LEDS-1:0] led;

    modport master (
        output pattern_in,
        input  led
    );

    modport slave (
        input  pattern_in,
        output led
    );

endinterface

// File: rtl/led_fader_fade_channel.sv
// Module: fade_channel
// One LED channel: brightness level register with saturating decay and a
// registered PWM comparator driving the active-low LED output.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   i_request_n  channel request, active-low (0 = snap to full brightness)
//   i_fade_tick  shared one-cycle decay strobe
//   i_pwm_cnt    shared free-running PWM counter
//   o_led_n      registered LED drive, active-low (0 = lit)
module fade_channel import led_pkg::*; #(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned FADE_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_request_n,
    input  logic                i_fade_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led_n
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_level_next;
    logic                r_led_n;

    // A request outranks a coincident fade tick, so a held LED never dips.
    // The decrement saturates at zero instead of wrapping to a bright level.
    always_comb begin
        w_level_next = r_level;
        if (!i_request_n) begin
            w_level_next = LEVEL_MAX;
        end else if (i_fade_tick) begin
            w_level_next = (r_level > STEP) ? (r_level - STEP) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            r_led_n <= 1'b1;
        end else begin
            r_level <= w_level_next;
            // Strict compare: level 0 never lights, LEVEL_MAX is dark only at pwm==LEVEL_MAX.
            r_led_n <= !(r_level > i_pwm_cnt);
        end
    end

    assign o_led_n = r_led_n;

endmodule

// File: rtl/led_fader.sv
// Module: led_fader
// Output stage between the LED pattern generator and the board LED pins.
// A requested LED snaps to full brightness; once released it decays in fixed
// steps, producing a comet-tail afterglow on a running-light pattern.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset (release is synchronous to clk)
//   bus  led_fader_if.slave: pattern_in (active-low request), led (active-low pins)
// Parameters:
//   NUMBER_OF_LEDS  channel count
//   PWM_BITS        brightness/PWM resolution
//   FADE_CYCLES     clk cycles between fade steps (>= 1)
//   FADE_STEP       brightness decrement per fade tick (1..LEVEL_MAX)
module led_fader import led_pkg::*; #(
    parameter int unsigned NUMBER_OF_LEDS = NUMBER_OF_LEDS_DEFAULT,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned FADE_CYCLES    = 270000,
    parameter int unsigned FADE_STEP      = 16
) (
    input  logic        clk,
    input  logic        rst,
    led_fader_if.slave  bus
);

    localparam int unsigned PRESCALE_BITS = $clog2(FADE_CYCLES + 1);
    localparam logic [PRESCALE_BITS-1:0] PRESCALE_LAST = PRESCALE_BITS'(FADE_CYCLES - 1);

    logic [PRESCALE_BITS-1:0]  r_prescaler;
    logic [PRESCALE_BITS-1:0]  w_prescaler_next;
    logic                      r_fade_tick;
    logic                      w_fade_tick_next;
    logic [PWM_BITS-1:0]       r_pwm_cnt;
    logic [NUMBER_OF_LEDS-1:0] w_led;

    // The tick flop is loaded from the next prescaler value so that it is high
    // exactly while the prescaler sits at FADE_CYCLES-1. With FADE_CYCLES=1 the
    // prescaler stays at 0 and the tick is high every cycle after reset.
    always_comb begin
        w_prescaler_next = (r_prescaler == PRESCALE_LAST) ? '0
                                                          : r_prescaler + PRESCALE_BITS'(1);
        w_fade_tick_next = (w_prescaler_next == PRESCALE_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescaler <= '0;
            r_fade_tick <= 1'b0;
            r_pwm_cnt   <= '0;
        end else begin
            r_prescaler <= w_prescaler_next;
            r_fade_tick <= w_fade_tick_next;
            r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar g = 0; g < NUMBER_OF_LEDS; g++) begin : g_ch
        fade_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_request_n (bus.pattern_in[g]),
            .i_fade_tick (r_fade_tick),
            .i_pwm_cnt   (r_pwm_cnt),
            .o_led_n     (w_led[g])
        );
    end

    assign bus.led = w_led;

endmodule

// File: tb/tb_led_fader.sv
// Testbench: tb_led_fader
// Directed sequence against a cycle-level reference model of the fader.
// Each clock step the model's expected LED word is queued and then popped
// against the DUT output; directed checks cover the called-out corner cases.
module tb_led_fader;
    import led_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned PB = 4;
    localparam int unsigned FC = 4;
    localparam int unsigned FS = 4;
    localparam int          LM = 15;

    logic clk = 1'b0;
    logic rst;

    led_fader_if #(.NUMBER_OF_LEDS(N)) bus ();

    led_fader #(
        .NUMBER_OF_LEDS (N),
        .PWM_BITS       (PB),
        .FADE_CYCLES    (FC),
        .FADE_STEP      (FS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_pre;
    logic       m_tick;
    int         m_pwm;
    int         m_level [N];
    logic [1:0] m_led;
    logic [1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre  = 0;
        m_tick = 1'b0;
        m_pwm  = 0;
        for (int i = 0; i < N; i++) m_level[i] = 0;
        m_led  = 2'b11;
    endtask

    // Advance one clock edge, update the model with the inputs seen at that edge,
    // queue the expected LED word and compare it against the DUT.
    task automatic step();
        logic [1:0] pin;
        int         nl [N];
        int         npre;
        logic [1:0] e;
        pin = bus.pattern_in;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!pin[i])      nl[i] = LM;
            else if (m_tick)  nl[i] = (m_level[i] > FS) ? m_level[i] - FS : 0;
            else              nl[i] = m_level[i];
            m_led[i] = !(m_level[i] > m_pwm);
        end
        m_pwm  = (m_pwm + 1) % (LM + 1);
        npre   = (m_pre == FC - 1) ? 0 : m_pre + 1;
        m_tick = (npre == FC - 1);
        m_pre  = npre;
        for (int i = 0; i < N; i++) m_level[i] = nl[i];
        exp_q.push_back(m_led);
        e = exp_q.pop_front();
        chk("led", 32'(bus.led), 32'(e));
        chk("tick", 32'(dut.r_fade_tick), 32'(m_tick));
        chk("lvl0", 32'(dut.g_ch[0].u_ch.r_level), 32'(m_level[0]));
        chk("lvl1", 32'(dut.g_ch[1].u_ch.r_level), 32'(m_level[1]));
    endtask

    initial begin
        int cnt;
        int idx;
        int k;
        logic t;
        int tbl [4];
        tbl = '{11, 7, 3, 0};

        // 1. Reset held with both channels requested
        rst = 1'b1;
        bus.pattern_in = 2'b00;
        model_reset();
        #1;
        chk("t1_rst_led_a", 32'(bus.led), 32'h3);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rst_led_b", 32'(bus.led), 32'h3);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t1_edge1_off", 32'(bus.led[0]), 32'h1);
        step();
        chk("t1_edge2_on", 32'(bus.led[0]), 32'h0);

        // 2. Full brightness duty on ch0, dark cycle lines up with pwm==15
        bus.pattern_in = 2'b10;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (bus.led[0] == 1'b0) cnt++;
            else chk("t2_hi_at_pwm15", 32'(dut.r_pwm_cnt), 32'h0);
        end
        chk("t2_low_count", cnt, 60);

        // 3. Release and decay with saturation at 0
        bus.pattern_in = 2'b11;
        idx = 0;
        k = 0;
        while (idx < 4 && k < 200) begin
            t = m_tick;
            step();
            if (t) begin
                chk("t3_decay_level", 32'(dut.g_ch[0].u_ch.r_level), 32'(tbl[idx]));
                idx++;
            end
            k++;
        end
        chk("t3_ticks_seen", idx, 4);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.led[0] == 1'b1) cnt++;
        end
        chk("t3_dark_count", cnt, 20);

        // 4. Request coincident with a fade tick wins
        bus.pattern_in = 2'b10;
        repeat (3) step();
        bus.pattern_in = 2'b11;
        k = 0;
        while (!(m_level[0] == 7 && m_tick) && k < 100) begin
            step();
            k++;
        end
        chk("t4_found_tick", 32'(dut.r_fade_tick), 32'h1);
        bus.pattern_in = 2'b10;
        step();
        chk("t4_req_wins", 32'(dut.g_ch[0].u_ch.r_level), 32'(LM));

        // 5. Shifting pattern, independent channels
        repeat (8) step();
        bus.pattern_in = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_ch1_full", 32'(dut.g_ch[1].u_ch.r_level), 32'(LM));
        end
        chk("t5_ch0_decayed", 32'(dut.g_ch[0].u_ch.r_level), 32'h0);

        // 6. Async reset mid-fade
        bus.pattern_in = 2'b10;
        repeat (4) step();
        bus.pattern_in = 2'b11;
        k = 0;
        while (m_level[0] != 7 && k < 100) begin
            step();
            k++;
        end
        chk("t6_level7", 32'(dut.g_ch[0].u_ch.r_level), 32'h7);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_led", 32'(bus.led), 32'h3);
        chk("t6_async_lvl0", 32'(dut.g_ch[0].u_ch.r_level), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        chk("t6_post_lvl0", 32'(dut.g_ch[0].u_ch.r_level), 32'h0);
        chk("t6_post_lvl1", 32'(dut.g_ch[1].u_ch.r_level), 32'h0);
        chk("t6_post_led", 32'(bus.led), 32'h3);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
